// File: rtl/floor_manager.sv
// Platform scroller for a vertical jumper game: four platform slots that scroll down
// while the slime is high, are respawned at the top with a pseudo-random x, and freeze on game over.
module floor_manager #(
    parameter logic [9:0]  SCROLL_LINE = 10'd200,
    parameter logic [9:0]  GROUND_Y    = 10'd479,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic [9:0]  slime_y,
    output logic [10:0] floor_pos_x0,
    output logic [10:0] floor_pos_x1,
    output logic [10:0] floor_pos_x2,
    output logic [10:0] floor_pos_x3,
    output logic [10:0] floor_pos_y0,
    output logic [10:0] floor_pos_y1,
    output logic [10:0] floor_pos_y2,
    output logic [10:0] floor_pos_y3,
    output logic [3:0]  enable,
    output logic [15:0] score,
    output logic        game_over
);

    localparam logic [1:0]  ST_RUN     = 2'd0;
    localparam logic [1:0]  ST_RESPAWN = 2'd1;
    localparam logic [1:0]  ST_OVER    = 2'd2;
    localparam logic [10:0] Y_LIMIT    = 11'd479;

    logic [1:0]  state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [10:0] x_q [4];
    logic [10:0] x_d [4];
    logic [10:0] y_q [4];
    logic [10:0] y_d [4];
    logic [3:0]  en_q, en_d;
    logic [15:0] score_q, score_d;
    logic        go_q, go_d;

    logic [3:0]  pending;
    logic [3:0]  remaining;
    logic [9:0]  rand_r;
    logic [10:0] rand_x;
    logic        serviced;

    // Fold the 0..1023 LFSR slice into the 0..599 playfield without a divider.
    assign rand_r = lfsr_q[9:0];
    assign rand_x = (rand_r <= 10'd599) ? {1'b0, rand_r} : {1'b0, rand_r - 10'd424};

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            pending[i] = (y_q[i] > Y_LIMIT);
        end
    end

    // Slots still waiting after the lowest-index one is serviced this cycle.
    assign remaining = pending & (pending - 4'd1);

    always_comb begin
        // NOTE: every next-state signal gets a hold default first so no path infers a latch.
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        en_d     = en_q;
        score_d  = score_q;
        go_d     = go_q;
        serviced = 1'b0;
        lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

        case (state_q)
            ST_RUN: begin
                if (slime_y == GROUND_Y) begin
                    state_d = ST_OVER;
                    go_d    = 1'b1;
                end else begin
                    for (int i = 0; i < 4; i++) begin
                        if (tick && (slime_y < SCROLL_LINE)) begin
                            y_d[i] = y_q[i] + 11'd1;
                        end
                        if (pending[i]) begin
                            en_d[i] = 1'b0;
                        end
                    end
                    if (|pending) begin
                        state_d = ST_RESPAWN;
                    end
                end
            end
            ST_RESPAWN: begin
                if (slime_y == GROUND_Y) begin
                    state_d = ST_OVER;
                    go_d    = 1'b1;
                end else begin
                    for (int i = 0; i < 4; i++) begin
                        if (pending[i] && !serviced) begin
                            serviced = 1'b1;
                            y_d[i]   = 11'd0;
                            x_d[i]   = rand_x;
                            en_d[i]  = 1'b1;
                            if (score_q != 16'hFFFF) begin
                                score_d = score_q + 16'd1;
                            end
                        end
                    end
                    if (remaining == 4'd0) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_OVER: begin
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            lfsr_q  <= LFSR_SEED;
            x_q[0]  <= 11'd300;
            x_q[1]  <= 11'd100;
            x_q[2]  <= 11'd420;
            x_q[3]  <= 11'd200;
            y_q[0]  <= 11'd120;
            y_q[1]  <= 11'd240;
            y_q[2]  <= 11'd360;
            y_q[3]  <= 11'd460;
            en_q    <= 4'b1111;
            score_q <= 16'd0;
            go_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            x_q     <= x_d;
            y_q     <= y_d;
            en_q    <= en_d;
            score_q <= score_d;
            go_q    <= go_d;
        end
    end

    assign floor_pos_x0 = x_q[0];
    assign floor_pos_x1 = x_q[1];
    assign floor_pos_x2 = x_q[2];
    assign floor_pos_x3 = x_q[3];
    assign floor_pos_y0 = y_q[0];
    assign floor_pos_y1 = y_q[1];
    assign floor_pos_y2 = y_q[2];
    assign floor_pos_y3 = y_q[3];
    assign enable       = en_q;
    assign score        = score_q;
    assign game_over    = go_q;

endmodule

// File: tb/tb_floor_manager.sv
// Directed bench for floor_manager: reset, scroll, hold, respawn with LFSR model, game over, reset in RESPAWN.
module tb_floor_manager;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic [9:0]  slime_y = 10'd250;
    logic [10:0] fx0, fx1, fx2, fx3, fy0, fy1, fy2, fy3;
    logic [3:0]  enable;
    logic [15:0] score;
    logic        game_over;

    int tests = 0;
    int fails = 0;

    logic [15:0] m_lfsr = 16'h0000;
    logic [15:0] m_prev = 16'h0000;
    logic [10:0] exp_x3;

    floor_manager dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .slime_y      (slime_y),
        .floor_pos_x0 (fx0),
        .floor_pos_x1 (fx1),
        .floor_pos_x2 (fx2),
        .floor_pos_x3 (fx3),
        .floor_pos_y0 (fy0),
        .floor_pos_y1 (fy1),
        .floor_pos_y2 (fy2),
        .floor_pos_y3 (fy3),
        .enable       (enable),
        .score        (score),
        .game_over    (game_over)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [10:0] map_x(input logic [15:0] l);
        logic [9:0] r;
        r = l[9:0];
        if (r <= 10'd599) return {1'b0, r};
        return {1'b0, r} - 11'd424;
    endfunction

    // Reference LFSR, stepped on the same edges as the design.
    always @(posedge clk) begin
        m_prev <= m_lfsr;
        m_lfsr <= rst ? 16'hACE1 : lfsr_next(m_lfsr);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_tick();
        @(negedge clk) tick = 1'b1;
        @(negedge clk) tick = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk) begin rst = 1'b1; tick = 1'b0; end
        @(negedge clk);
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " x0"}, fx0, 300);
        check({tag, " x1"}, fx1, 100);
        check({tag, " x2"}, fx2, 420);
        check({tag, " x3"}, fx3, 200);
        check({tag, " y0"}, fy0, 120);
        check({tag, " y1"}, fy1, 240);
        check({tag, " y2"}, fy2, 360);
        check({tag, " y3"}, fy3, 460);
        check({tag, " en"}, enable, 4'b1111);
        check({tag, " score"}, score, 0);
        check({tag, " go"}, game_over, 0);
    endtask

    initial begin
        // Reset and hold with tick low
        do_reset();
        check_reset_vals("rst");
        @(negedge clk);
        @(negedge clk);
        check_reset_vals("rst_hold");

        // Scroll below the line
        slime_y = 10'd150;
        repeat (10) do_tick();
        check("scroll y0", fy0, 130);
        check("scroll y1", fy1, 250);
        check("scroll y2", fy2, 370);
        check("scroll y3", fy3, 470);
        check("scroll x0", fx0, 300);
        check("scroll x3", fx3, 200);
        check("scroll score", score, 0);

        // Above the line: hold
        slime_y = 10'd250;
        repeat (10) do_tick();
        check("noscroll y0", fy0, 130);
        check("noscroll y3", fy3, 470);

        // Line boundary: equal holds, one below scrolls
        slime_y = 10'd200;
        do_tick();
        check("line200 y0", fy0, 130);
        slime_y = 10'd199;
        do_tick();
        check("line199 y0", fy0, 131);
        check("line199 y3", fy3, 471);

        // Respawn of slot 3 after 20 ticks from reset
        do_reset();
        slime_y = 10'd150;
        repeat (20) do_tick();
        check("pre_retire y3", fy3, 480);
        check("pre_retire en", enable, 4'b1111);
        @(negedge clk);
        check("retire en", enable, 4'b0111);
        check("retire y3", fy3, 480);
        check("retire score", score, 0);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        exp_x3 = map_x(m_prev);
        check("respawn y3", fy3, 0);
        check("respawn x3", fx3, exp_x3);
        check("respawn x3 range", fx3 <= 11'd599, 1);
        check("respawn en", enable, 4'b1111);
        check("respawn score", score, 1);
        check("tick dropped y0", fy0, 140);
        do_tick();
        check("after y0", fy0, 141);
        check("after y3", fy3, 1);

        // Game over freezes everything
        @(negedge clk) slime_y = 10'd479;
        @(negedge clk);
        check("go set", game_over, 1);
        repeat (25) do_tick();
        slime_y = 10'd150;
        repeat (25) do_tick();
        check("go held", game_over, 1);
        check("go y0", fy0, 141);
        check("go y1", fy1, 261);
        check("go y2", fy2, 381);
        check("go y3", fy3, 1);
        check("go x0", fx0, 300);
        check("go x3", fx3, exp_x3);
        check("go en", enable, 4'b1111);
        check("go score", score, 1);

        // Reset during a RESPAWN cycle
        do_reset();
        check_reset_vals("rst_from_over");
        slime_y = 10'd150;
        repeat (20) do_tick();
        @(negedge clk);
        check("mid retire en", enable, 4'b0111);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_vals("rst_mid");
        @(negedge clk);
        check("rst_mid hold en", enable, 4'b1111);
        check("rst_mid hold score", score, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/floor_manager.md
FLOOR_MANAGER -- requirements
Module: floor_manager

Interface
REQ-001 Parameter SCROLL_LINE, default 10'd200: slime_y strictly below this value triggers scrolling.
REQ-002 Parameter GROUND_Y, default 10'd479: slime_y equal to this value ends the game.
REQ-003 Parameter LFSR_SEED, default 16'hACE1: LFSR reset value; must be non-zero.
REQ-004 clk  input  1  single system clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 tick  input  1  one-cycle movement strobe, same rate as slime motion steps.
REQ-007 slime_y  input  10  current slime vertical position.
REQ-008 floor_pos_x0..floor_pos_x3  output  11 each  platform left edge, range 0..599.
REQ-009 floor_pos_y0..floor_pos_y3  output  11 each  platform top row.
REQ-010 enable  output  4  bit i=1 when platform i is valid for landing.
REQ-011 score  output  16  count of platforms retired.
REQ-012 game_over  output  1  high once the slime has reached ground.

Function
REQ-013 FSM states: RUN, RESPAWN, OVER; reset state RUN.
REQ-014 LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifts every clk cycle in every state.
REQ-015 Random x: r = lfsr[9:0]; x = r when r <= 599, else r - 424; result always 0..599, zero-extended to 11 bits.
REQ-016 RUN, tick=1, slime_y < SCROLL_LINE: every floor_pos_yi increments by 1 in that cycle; x unchanged.
REQ-017 RUN, tick=1, slime_y >= SCROLL_LINE: floor positions hold.
REQ-018 RUN, tick=0: floor positions hold.
REQ-019 Retire: in RUN, any slot with floor_pos_yi > 479 clears enable[i] and moves the FSM to RESPAWN in the next cycle.
REQ-020 RESPAWN: each cycle services the lowest-index slot with y > 479:
- y := 0
- x := random x (REQ-015)
- enable bit := 1
- score += 1, saturating at 16'hFFFF
REQ-021 RESPAWN returns to RUN in the cycle after the last pending slot is serviced.
REQ-022 tick asserted outside RUN is dropped, not queued.
REQ-023 A retired slot holds enable=0 from the cycle after its y exceeds 479 until it is serviced.
REQ-024 slime_y == GROUND_Y, sampled in RUN or RESPAWN: next state OVER and game_over := 1.
REQ-025 Ground detect has priority over scroll and respawn in the same cycle.
REQ-026 OVER is absorbing:
- positions, enable and score frozen
- game_over held at 1
- exit only by rst
REQ-027 Add/compare widths: y arithmetic in 11 bits so y=480 is representable; 11'd2047 never reached in operation.
REQ-028 Outputs are registered; latency from tick to changed y is one clock.

Reset
REQ-029 rst=1 at a clock edge, in any state including mid-RESPAWN, gives on the next cycle:
- state RUN
- x0..x3 = 300, 100, 420, 200
- y0..y3 = 120, 240, 360, 460
- enable = 4'b1111
- score = 0
- game_over = 0
- lfsr = LFSR_SEED
REQ-030 rst has priority over tick, slime_y and every FSM transition.

Verification
REQ-031 Reset check: rst for 2 cycles, then release -> all outputs hold the REQ-029 values while tick=0.
REQ-032 Scroll: slime_y=150, 10 ticks -> y = 130, 250, 370, 470; x unchanged; score 0.
REQ-033 No scroll: slime_y=250, 10 ticks -> all y unchanged.
REQ-034 Respawn (slime_y=150):
- after 20 ticks y3 = 480 -> next cycle enable[3]=0
- following cycle y3=0, x3 equals the bench LFSR model mapping, enable[3]=1, score=1
- x3 within 0..599 in every case
REQ-035 Game over: slime_y=479 in RUN -> game_over=1 next cycle; 50 further ticks leave y, x, enable and score unchanged.
REQ-036 Reset mid-operation: rst asserted during a RESPAWN cycle -> REQ-029 values next cycle and no score increment.
